// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with load-use bubble insertion, EX back-pressure hold,
// flush, and saturating bubble/stall performance counters.
module id_ex_stage #(
    parameter int unsigned CTRL_W = 24,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              valid_ID,
    output logic              ready_ID,
    input  logic              rd_after_ld_hazard,
    input  logic [31:0]       pc_ID,
    input  logic [31:0]       imm_ID,
    input  logic [31:0]       rs1_data,
    input  logic [31:0]       rs2_data,
    input  logic [31:0]       rs3_data,
    input  logic              rd_wena_ID,
    input  logic [5:0]        rd_addr_ID,
    input  logic [2:0]        wb_src_ID,
    input  logic [CTRL_W-1:0] ctrl_ID,
    input  logic              ready_EX,
    output logic              valid_EX,
    output logic [31:0]       pc_EX,
    output logic [31:0]       imm_EX,
    output logic [31:0]       rs1_data_EX,
    output logic [31:0]       rs2_data_EX,
    output logic [31:0]       rs3_data_EX,
    output logic              rd_wena_EX,
    output logic [5:0]        rd_addr_EX,
    output logic [2:0]        wb_src_EX,
    output logic [CTRL_W-1:0] ctrl_EX,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              valid_q;
    logic              wena_q;
    logic [31:0]       pc_q;
    logic [31:0]       imm_q;
    logic [31:0]       rs1_q;
    logic [31:0]       rs2_q;
    logic [31:0]       rs3_q;
    logic [5:0]        rd_addr_q;
    logic [2:0]        wb_src_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [CNT_W-1:0]  bubble_q;
    logic [CNT_W-1:0]  stall_q;

    logic advance;
    logic load;
    logic bubble_inc;
    logic stall_inc;

    // Decode the per-edge action; flush outranks stall and bubble counting.
    always_comb begin
        advance    = !valid_q || ready_EX;
        ready_ID   = advance && !rd_after_ld_hazard && !flush;
        load       = ready_ID && valid_ID;
        bubble_inc = !flush && advance && rd_after_ld_hazard && valid_ID;
        stall_inc  = !flush && !advance;
    end

    // Valid/rd_wena: cleared on flush, bubble or empty slot; held while stalled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            wena_q  <= 1'b0;
        end else if (flush || advance) begin
            valid_q <= load;
            wena_q  <= load && rd_wena_ID;
        end
    end

    // Payload registers only capture on an accepted ID instruction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q      <= '0;
            imm_q     <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rs3_q     <= '0;
            rd_addr_q <= '0;
            wb_src_q  <= '0;
            ctrl_q    <= '0;
        end else if (load) begin
            pc_q      <= pc_ID;
            imm_q     <= imm_ID;
            rs1_q     <= rs1_data;
            rs2_q     <= rs2_data;
            rs3_q     <= rs3_data;
            rd_addr_q <= rd_addr_ID;
            wb_src_q  <= wb_src_ID;
            ctrl_q    <= ctrl_ID;
        end
    end

    // Saturating performance counters, cleared only by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bubble_q <= '0;
            stall_q  <= '0;
        end else begin
            if (bubble_inc && (bubble_q != {CNT_W{1'b1}})) bubble_q <= bubble_q + CNT_W'(1);
            if (stall_inc && (stall_q != {CNT_W{1'b1}}))   stall_q  <= stall_q + CNT_W'(1);
        end
    end

    assign valid_EX    = valid_q;
    assign rd_wena_EX  = wena_q && valid_q;
    assign pc_EX       = pc_q;
    assign imm_EX      = imm_q;
    assign rs1_data_EX = rs1_q;
    assign rs2_data_EX = rs2_q;
    assign rs3_data_EX = rs3_q;
    assign rd_addr_EX  = rd_addr_q;
    assign wb_src_EX   = wb_src_q;
    assign ctrl_EX     = ctrl_q;
    assign bubble_cnt  = bubble_q;
    assign stall_cnt   = stall_q;

endmodule
